// File: rtl/rsa_box_cmd_master.sv
// rtl/rsa_box_cmd_master.sv - command-driven bus initiator for the RSA box register slave
//
// Accepts one command (instruction, up to MAX_WORDS payload words, result word count),
// writes the instruction at address 0 and the payload at addresses 1..N, reads results
// from addresses 0..M-1, then presents the packed results on a valid/ready response port.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (ready only while idle)
//   cmd_instr, cmd_nwords, cmd_data,   command contents; counts above MAX_WORDS clamp
//   cmd_nread
//   rsp_valid/rsp_ready, rsp_data      response handshake and packed read words
//   busy                               high whenever a command is in flight
//   chipselect, write, address,        registered slave bus; readdata arrives
//   data_in, data_out                  READ_LATENCY cycles after the read strobe
module rsa_box_cmd_master #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 3,
    parameter int MAX_WORDS    = 4,
    parameter int READ_LATENCY = 1,
    parameter int IDLE_ADDR    = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DATA_W-1:0]           cmd_instr,
    input  logic [2:0]                  cmd_nwords,
    input  logic [MAX_WORDS*DATA_W-1:0] cmd_data,
    input  logic [2:0]                  cmd_nread,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [MAX_WORDS*DATA_W-1:0] rsp_data,
    output logic                        busy,
    output logic                        chipselect,
    output logic                        write,
    output logic [ADDR_W-1:0]           address,
    output logic [DATA_W-1:0]           data_in,
    input  logic [DATA_W-1:0]           data_out
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_INSTR = 3'd1;
    localparam logic [2:0] ST_WR_DATA  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    localparam logic [2:0]        MAX_N     = 3'(MAX_WORDS);
    localparam int                WAIT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] PARK_ADDR = ADDR_W'(IDLE_ADDR);

    logic [2:0]                  state, state_d;
    logic [2:0]                  k, k_d;          // payload beat index
    logic [2:0]                  j, j_d;          // result word index
    logic [WAIT_W-1:0]           w, w_d;          // read latency counter
    logic [2:0]                  nwords_q, nread_q;
    logic [MAX_WORDS*DATA_W-1:0] data_q;
    logic                        accept, capture;
    logic                        cs_d, wr_d;
    logic [ADDR_W-1:0]           addr_d;
    logic [DATA_W-1:0]           din_d;

    always_comb begin
        state_d = state;
        k_d     = k;
        j_d     = j;
        w_d     = w;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = ST_WR_INSTR;
                end
            end
            ST_WR_INSTR: begin
                k_d = 3'd0;
                j_d = 3'd0;
                if (nwords_q != 3'd0)     state_d = ST_WR_DATA;
                else if (nread_q != 3'd0) state_d = ST_RD_ISSUE;
                else                      state_d = ST_RESP;
            end
            ST_WR_DATA: begin
                if (k + 3'd1 == nwords_q) state_d = (nread_q != 3'd0) ? ST_RD_ISSUE : ST_RESP;
                else                      k_d = k + 3'd1;
            end
            ST_RD_ISSUE: begin
                w_d     = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w == WAIT_LAST) begin
                    capture = 1'b1;
                    if (j + 3'd1 == nread_q) begin
                        state_d = ST_RESP;
                    end else begin
                        j_d     = j + 3'd1;
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    w_d = w + WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each access appears exactly
    // in the cycle its state occupies. WR_INSTR is only entered from IDLE, so the
    // instruction is taken straight from the command port at acceptance.
    always_comb begin
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        addr_d = PARK_ADDR;
        din_d  = '0;
        case (state_d)
            ST_WR_INSTR: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = '0;
                din_d  = cmd_instr;
            end
            ST_WR_DATA: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_W'(k_d + 3'd1);
                din_d  = data_q[k_d*DATA_W +: DATA_W];
            end
            ST_RD_ISSUE: begin
                cs_d   = 1'b1;
                addr_d = ADDR_W'(j_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            k          <= 3'd0;
            j          <= 3'd0;
            w          <= '0;
            nwords_q   <= 3'd0;
            nread_q    <= 3'd0;
            data_q     <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= PARK_ADDR;
            data_in    <= '0;
        end else begin
            state <= state_d;
            k     <= k_d;
            j     <= j_d;
            w     <= w_d;
            if (accept) begin
                nwords_q <= (cmd_nwords > MAX_N) ? MAX_N : cmd_nwords;
                nread_q  <= (cmd_nread > MAX_N) ? MAX_N : cmd_nread;
                data_q   <= cmd_data;
                rsp_data <= '0;
            end
            if (capture) rsp_data[j*DATA_W +: DATA_W] <= data_out;
            cmd_ready  <= (state_d == ST_IDLE);
            busy       <= (state_d != ST_IDLE);
            // rsp_valid rises one cycle after RESP is entered and drops on the handshake edge.
            rsp_valid  <= (state == ST_RESP) && (state_d == ST_RESP);
            chipselect <= cs_d;
            write      <= wr_d;
            address    <= addr_d;
            data_in    <= din_d;
        end
    end

endmodule

// File: tb/tb_rsa_box_cmd_master.sv
// tb/tb_rsa_box_cmd_master.sv - directed self-checking bench for rsa_box_cmd_master
module tb_rsa_box_cmd_master;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_instr = '0;
    logic [2:0]   cmd_nwords = '0;
    logic [127:0] cmd_data = '0;
    logic [2:0]   cmd_nread = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         busy;
    logic         chipselect;
    logic         write;
    logic [2:0]   address;
    logic [31:0]  data_in;
    logic [31:0]  data_out = '0;

    int total = 0;
    int bad = 0;
    int addr0_bad = 0;

    logic [2:0]  wa[$];
    logic [31:0] wd[$];
    logic [2:0]  rd[$];

    rsa_box_cmd_master dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_instr  (cmd_instr),
        .cmd_nwords (cmd_nwords),
        .cmd_data   (cmd_data),
        .cmd_nread  (cmd_nread),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Slave model: registered readdata, word at address a reads back 0x00010001*(a+1).
    always @(posedge clk) begin
        if (chipselect && !write) data_out <= 32'h00010001 * (32'(address) + 32'd1);
    end

    // Bus monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect && write) begin
                wa.push_back(address);
                wd.push_back(data_in);
            end else if (chipselect) begin
                rd.push_back(address);
            end
            if (address == 3'd0 && !chipselect) addr0_bad++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        rd.delete();
    endtask

    task automatic send_cmd(input logic [31:0] instr, input logic [2:0] nw,
                            input logic [127:0] d, input logic [2:0] nr);
        clear_log();
        cmd_instr  = instr;
        cmd_nwords = nw;
        cmd_data   = d;
        cmd_nread  = nr;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_instr  = '1;
        cmd_data   = '1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [31:0] instr, input int n,
                                input logic [127:0] d);
        chk({tag, "_nwr"}, 128'(wa.size()), 128'(n + 1));
        for (int i = 0; i <= n; i++) begin
            logic [34:0] e;
            e = (i == 0) ? {3'd0, instr} : {3'(i), d[(i-1)*32 +: 32]};
            chk($sformatf("%s_wr%0d", tag, i), 128'({wa[i], wd[i]}), 128'(e));
        end
    endtask

    task automatic check_reads(input string tag, input int n);
        chk({tag, "_nrd"}, 128'(rd.size()), 128'(n));
        for (int i = 0; i < n; i++) chk($sformatf("%s_rd%0d", tag, i), 128'(rd[i]), 128'(i));
    endtask

    initial begin
        int lat;
        logic [127:0] d;
        logic [127:0] held;
        logic [127:0] exp6;
        int stable_bad;
        int seen;

        // 1: reset state
        @(negedge clk);
        chk("rst_cs", 128'(chipselect), 128'd0);
        chk("rst_write", 128'(write), 128'd0);
        chk("rst_addr", 128'(address), 128'd7);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 2: four writes, no reads
        d = 128'h44444444_33333333_22222222_11111111;
        send_cmd(32'd2, 3'd4, d, 3'd0);
        chk("t2_busy", 128'(busy), 128'd1);
        chk("t2_cmd_ready", 128'(cmd_ready), 128'd0);
        wait_rsp(lat);
        chk("t2_latency", 128'(lat), 128'd6);
        chk("t2_rsp_data", rsp_data, 128'd0);
        check_writes("t2", 32'd2, 4, d);
        check_reads("t2", 0);
        finish_rsp();
        chk("t2_idle_ready", 128'(cmd_ready), 128'd1);
        chk("t2_rsp_drop", 128'(rsp_valid), 128'd0);

        // 3: one write, one read
        d = 128'h0000000000000000_00000000_AAAA5555;
        send_cmd(32'd9, 3'd1, d, 3'd1);
        wait_rsp(lat);
        chk("t3_latency", 128'(lat), 128'd5);
        chk("t3_rsp_data", rsp_data, 128'h00010001);
        check_writes("t3", 32'd9, 1, d);
        check_reads("t3", 1);

        // 4: response back-pressure
        held = 128'h00010001;
        stable_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_data === held && cmd_ready === 1'b0 &&
                  chipselect === 1'b0 && busy === 1'b1)) stable_bad++;
        end
        chk("t4_hold_stable", 128'(stable_bad), 128'd0);
        finish_rsp();
        chk("t4_rsp_drop", 128'(rsp_valid), 128'd0);
        chk("t4_idle_busy", 128'(busy), 128'd0);
        chk("t4_idle_ready", 128'(cmd_ready), 128'd1);

        // 5: reset during the third payload beat
        d = 128'h44444444_33333333_22222222_11111111;
        send_cmd(32'd3, 3'd4, d, 3'd2);
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("t5_beat2_addr", 128'(address), 128'd3);
        chk("t5_beat2_cs", 128'(chipselect), 128'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_cs", 128'(chipselect), 128'd0);
        chk("t5_async_addr", 128'(address), 128'd7);
        chk("t5_async_ready", 128'(cmd_ready), 128'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || chipselect !== 1'b0) seen++;
        end
        chk("t5_no_rsp", 128'(seen), 128'd0);
        d = 128'h0000000000000000_00000000_12345678;
        send_cmd(32'd3, 3'd1, d, 3'd0);
        wait_rsp(lat);
        chk("t5_latency", 128'(lat), 128'd3);
        chk("t5_rsp_data", rsp_data, 128'd0);
        check_writes("t5", 32'd3, 1, d);
        check_reads("t5", 0);
        finish_rsp();

        // 6: oversize counts clamp to four
        d = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        send_cmd(32'd5, 3'd7, d, 3'd6);
        wait_rsp(lat);
        chk("t6_latency", 128'(lat), 128'd14);
        exp6 = 128'h00040004_00030003_00020002_00010001;
        chk("t6_rsp_data", rsp_data, exp6);
        check_writes("t6", 32'd5, 4, d);
        check_reads("t6", 4);
        finish_rsp();
        chk("t6_idle_ready", 128'(cmd_ready), 128'd1);
        chk("addr0_outside_access", 128'(addr0_bad), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
